// File: rtl/arith_result_serializer.sv
// arith_result_serializer: captures the five arithmetic results in one handshake
// and streams them as tagged words, optionally closed by an XOR checksum word.
module arith_result_serializer #(
    parameter int unsigned WIDTH       = 8,
    parameter bit          EN_CHECKSUM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] res1,
    input  logic [WIDTH-1:0] res2,
    input  logic [WIDTH-1:0] res3,
    input  logic [WIDTH-1:0] res4,
    input  logic [WIDTH-1:0] res5,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_tag,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned NWORDS = 6;
    localparam logic [2:0]  LAST   = EN_CHECKSUM ? 3'd5 : 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [WIDTH-1:0] bank_q [NWORDS];
    logic [WIDTH-1:0] checksum;
    logic             capture;
    logic             frame_done;

    // Checksum word: plain bitwise XOR of the five results.
    assign checksum = res1 ^ res2 ^ res3 ^ res4 ^ res5;

    // Next-state and output decode; in_ready in SEND is the only path from out_ready.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_tag    = 3'd0;
        out_last   = 1'b0;
        capture    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = bank_q[idx_q];
                out_tag   = idx_q;
                out_last  = (idx_q == LAST);
                in_ready  = out_ready && (idx_q == LAST);
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        frame_done = 1'b1;
                        idx_d      = 3'd0;
                        if (in_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State, word index and completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            frame_cnt <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Word bank: results are sampled only on the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (capture) begin
            bank_q[0] <= res1;
            bank_q[1] <= res2;
            bank_q[2] <= res3;
            bank_q[3] <= res4;
            bank_q[4] <= res5;
            bank_q[5] <= checksum;
        end
    end

endmodule

// File: tb/tb_arith_result_serializer.sv
// Bench for arith_result_serializer: directed steps with a scoreboard of expected beats.
module tb_arith_result_serializer;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] tag;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] res1, res2, res3, res4, res5;
    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic [2:0] out_tag;
    logic [15:0] frame_cnt;
    logic       in_valid0, in_ready0, out_valid0, out_ready0, out_last0;
    logic [7:0] out_data0;
    logic [2:0] out_tag0;
    logic [15:0] frame_cnt0;

    beat_t q[$];
    beat_t q0[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    arith_result_serializer #(.WIDTH(8), .EN_CHECKSUM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .res1(res1), .res2(res2), .res3(res3), .res4(res4), .res5(res5),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_tag(out_tag), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt)
    );

    arith_result_serializer #(.WIDTH(8), .EN_CHECKSUM(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .res1(res1), .res2(res2), .res3(res3), .res4(res4), .res5(res5),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_tag(out_tag0), .out_last(out_last0),
        .out_valid(out_valid0), .out_ready(out_ready0), .frame_cnt(frame_cnt0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_res(input logic [7:0] a, b, c, d, e);
        res1 = a; res2 = b; res3 = c; res4 = d; res5 = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the selected instance has finished its frame.
    task automatic wait_idle(input bit which);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!(which ? out_valid0 : out_valid)) begin
                done = 1'b1;
                break;
            end
        end
        chk(which ? "idle_timeout0" : "idle_timeout", 32'(done), 32'd1);
    endtask

    // Scoreboard: pop/compare on output handshakes, push expected beats on captures.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                chk("beat_queued", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    beat_t e;
                    e = q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.data));
                    chk("sb_tag",  32'(out_tag),  32'(e.tag));
                    chk("sb_last", 32'(out_last), 32'(e.last));
                end
            end
            if (out_valid0 && out_ready0) begin
                chk("beat_queued0", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) begin
                    beat_t e;
                    e = q0.pop_front();
                    chk("sb0_data", 32'(out_data0), 32'(e.data));
                    chk("sb0_tag",  32'(out_tag0),  32'(e.tag));
                    chk("sb0_last", 32'(out_last0), 32'(e.last));
                end
            end
            if (in_valid && in_ready) begin
                logic [7:0] w [6];
                w[0] = res1; w[1] = res2; w[2] = res3; w[3] = res4; w[4] = res5;
                w[5] = res1 ^ res2 ^ res3 ^ res4 ^ res5;
                for (int i = 0; i < 6; i++) q.push_back('{data: w[i], tag: 3'(i), last: (i == 5)});
            end
            if (in_valid0 && in_ready0) begin
                logic [7:0] w [5];
                w[0] = res1; w[1] = res2; w[2] = res3; w[3] = res4; w[4] = res5;
                for (int i = 0; i < 5; i++) q0.push_back('{data: w[i], tag: 3'(i), last: (i == 4)});
            end
        end
    end

    initial begin
        bit seen;
        clk = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_valid0 = 1'b0;
        out_ready = 1'b1; out_ready0 = 1'b1;
        set_res(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame with checksum
        set_res(8'h12, 8'h0E, 8'h20, 8'h08, 8'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_tag",   32'(out_tag),   32'd0);
        chk("lat_data",  32'(out_data),  32'h12);
        wait_idle(1'b0);
        chk("basic_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("basic_in_ready",  32'(in_ready),  32'd1);

        // Backpressure at tag 2 for three cycles
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_tag",      32'(out_tag),   32'd2);
            chk("bp_data",     32'(out_data),  32'h20);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle(1'b0);
        chk("bp_frame_cnt", 32'(frame_cnt), 32'd2);

        // Back-to-back frames; inputs change after capture
        tick();
        set_res(8'h12, 8'h0E, 8'h20, 8'h08, 8'h00);
        in_valid = 1'b1;
        tick();
        set_res(8'h09, 8'h05, 8'h0E, 8'h03, 8'h01);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready && out_valid) begin
                seen = 1'b1;
                chk("b2b_cap_tag", 32'(out_tag), 32'd5);
                break;
            end
        end
        chk("b2b_handshake", 32'(seen), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_nogap_valid", 32'(out_valid), 32'd1);
        chk("b2b_nogap_tag",   32'(out_tag),   32'd0);
        chk("b2b_nogap_data",  32'(out_data),  32'h09);
        wait_idle(1'b0);
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'd4);

        // Five-word frames without checksum
        tick();
        set_res(8'h12, 8'h0E, 8'h20, 8'h08, 8'h00);
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        wait_idle(1'b1);
        chk("nock_frame_cnt", 32'(frame_cnt0), 32'd1);
        chk("nock_queue_empty", 32'(q0.size()), 32'd0);

        // Asynchronous reset during tag 3
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_tag", 32'(out_tag), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        q.delete();
        tick();
        rst_n = 1'b1;
        set_res(8'h09, 8'h05, 8'h0E, 8'h03, 8'h01);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_tag",  32'(out_tag),  32'd0);
        chk("post_rst_data", 32'(out_data), 32'h09);
        wait_idle(1'b0);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Counter wrap
        tick();
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        tick();
        chk("wrap_preset", 32'(frame_cnt), 32'hFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_idle(1'b0);
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'h0000);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
